csi_stream_scheduler: RTL
=========================

// Module: csi_stream_scheduler
// PURPOSE
//  Frame-granular round-robin arbiter sharing one CSI AXI-stream output (to DMA) between N_CHAN
//  csi_extractor_sv instances (one per antenna/RF chain). Each granted frame gets a one-word header
//  (tag, channel, sequence number). Over-length frames are truncated and their remaining beats discarded.
// PARAMETERS
//  N_CHAN   4      number of CSI sources, 1..16
//  MAX_LEN  64     max data beats forwarded per frame (64 subcarriers)
//  HDR_TAG  8'hC5  header tag byte
// PORTS
//  clk_in            in   1          single clock domain
//  rst_in            in   1          synchronous reset, active-high
//  s_axis_tvalid     in   N_CHAN     per-source valid
//  s_axis_tlast      in   N_CHAN     per-source end of frame
//  s_axis_tdata      in   32*N_CHAN  source c occupies [32*c+31:32*c]
//  s_axis_tready     out  N_CHAN     per-source ready
//  m_axis_tvalid     out  1          merged stream valid
//  m_axis_tlast      out  1          last beat of header+frame
//  m_axis_tdata      out  32         header or CSI word
//  m_axis_tready     in   1          downstream ready
//  cfg_chan_en_in    in   N_CHAN     1 = source may be granted
//  busy_out          out  1          state != IDLE or output register full
//  trunc_pulse_out   out  1          1-cycle pulse when a frame is truncated
//  seq_out           out  16         sequence number of the next header
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE; seq 0; last_grant = N_CHAN-1 (so channel 0 wins first).
//  - Reset mid-frame abandons the frame immediately. No partial beats are emitted after reset.
//  Output register:
//  - m_axis_* is one register stage, free when !m_axis_tvalid || m_axis_tready.
//  - The register holds its contents while m_axis_tvalid && !m_axis_tready.
//  FSM states:
//  - IDLE:
//    - Requests = s_axis_tvalid & cfg_chan_en_in.
//    - If any request, grant the first channel found searching last_grant+1 upward, wrapping mod N_CHAN.
//    - Latch grant, clear beat_cnt, go to HDR.
//    - No grant when there are no requests.
//  - HDR:
//    - When the output register is free, load {HDR_TAG, 4'(grant), 4'h0, seq} with tlast=0.
//    - Then seq <= seq+1 (wraps at 16'hFFFF -> 0) and go to DATA.
//  - DATA:
//    - s_axis_tready[grant] = output register free. All other tready bits are 0.
//    - On source handshake: load tdata into the output register, beat_cnt++.
//      Output tlast = src tlast || beat_cnt == MAX_LEN-1.
//    - If src tlast: go to IDLE.
//    - Else if beat_cnt == MAX_LEN-1: pulse trunc_pulse_out and go to DRAIN.
//  - DRAIN:
//    - s_axis_tready[grant] = 1. Beats are discarded.
//    - On a src tlast handshake, go to IDLE.
//  Timing and ordering rules:
//  - Latency: a source beat appears on m_axis the cycle after its handshake.
//  - Header is one cycle after the grant, given the output register is free.
//  - Arbitration happens only in IDLE.
//  - cfg_chan_en_in changes mid-frame never abort the current frame. They take effect at the next IDLE.
//  - last_grant updates at grant time.
//  - A source that deasserts tvalid mid-frame stalls the scheduler. There is no timeout; that is the
//    upstream's responsibility.
//  - IDLE may grant while the output register still holds the previous frame's last beat. The HDR load
//    waits for the register to be free; back-to-back frames have no bubble beyond the grant cycle.
//  - m_axis_tdata/tlast must be stable while m_axis_tvalid && !m_axis_tready (AXI rule).
//  - A frame with tlast on its first beat is legal: output is header + 1 beat.
// TESTING
//  - Single source 0, 64-beat frame, tready=1:
//    -> header C5_0_0_0000, then 64 words in order; tlast on word 65; seq_out=1.
//  - All 4 sources valid continuously with 64-beat frames:
//    -> grant order 0,1,2,3,0; headers carry chan 0..3 and seq 0..4; no interleaving within a frame.
//  - Source 2 sends 80 beats, MAX_LEN=64:
//    -> 64 data words output, tlast on the 64th, one trunc pulse; the remaining 16 beats are accepted
//       and dropped; next frame header follows.
//  - Random m_axis_tready (50%) over 100 frames:
//    -> scoreboard exact match, data/tlast stable while stalled, no beat lost or duplicated.
//  - cfg_chan_en_in=4'b1010 with all sources valid:
//    -> only chan 1,3 granted, alternating. Clearing bit 1 mid-frame of chan 1 -> frame completes.
//  - rst_in asserted at beat 30 of a frame:
//    -> next cycle m_axis_tvalid=0, seq_out=0; the first post-reset frame is granted to channel 0.

Source files
------------

// File: rtl/csi_stream_scheduler.sv
// -----------------------------------------------------------------------------
// csi_stream_scheduler
//
// Shares one CSI AXI-stream output (towards DMA) between N_CHAN extractor
// sources. Whole frames are granted round-robin. Each granted frame is
// preceded by a one-word header {HDR_TAG, channel, 4'h0, sequence}. A frame
// longer than MAX_LEN beats is cut at MAX_LEN beats, and tlast is forced on
// the final forwarded beat. The remaining source beats are accepted and
// discarded.
//
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   s_axis_*            per-source streams; source c uses tdata[32*c +: 32]
//   m_axis_*            merged output, driven from a single register stage
//   cfg_chan_en_in      per-source grant enable, sampled only when idle
//   busy_out            a frame is in progress or the output register is full
//   trunc_pulse_out     one-cycle pulse; it coincides with the truncated last beat
//   seq_out             sequence number the next header will carry
// -----------------------------------------------------------------------------
module csi_stream_scheduler #(
  parameter int         N_CHAN  = 4,
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] HDR_TAG = 8'hC5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [N_CHAN-1:0]     s_axis_tvalid,
  input  logic [N_CHAN-1:0]     s_axis_tlast,
  input  logic [32*N_CHAN-1:0]  s_axis_tdata,
  output logic [N_CHAN-1:0]     s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [31:0]           m_axis_tdata,
  input  logic                  m_axis_tready,
  input  logic [N_CHAN-1:0]     cfg_chan_en_in,
  output logic                  busy_out,
  output logic                  trunc_pulse_out,
  output logic [15:0]           seq_out
);

  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int BW = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]     seq_q, seq_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [31:0]     m_data_q, m_data_d;
  logic            trunc_q, trunc_d;

  // Unpack the flat source data bus into one word per channel.
  logic [31:0] src_data [N_CHAN];
  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_unpack
    assign src_data[gi] = s_axis_tdata[32*gi +: 32];
  end

  logic [N_CHAN-1:0] req;
  logic [CW-1:0]     pick;
  logic              pick_vld;
  logic              out_free;
  logic              at_max;

  assign req      = s_axis_tvalid & cfg_chan_en_in;
  assign out_free = !m_valid_q || m_axis_tready;
  assign at_max   = (beat_cnt_q == BW'(MAX_LEN - 1));

  // Round-robin search starting just after last_grant. The loop runs from the
  // farthest offset down to the nearest one, so the nearest requester is
  // written last and wins.
  always_comb begin : rr_search
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N_CHAN; i >= 1; i--) begin
      idx = int'(last_grant_q) + i;
      if (idx >= N_CHAN) idx = idx - N_CHAN;
      if (req[CW'(idx)]) begin
        pick     = CW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    seq_d         = seq_q;
    // A word the sink accepts this cycle leaves the register unless something
    // new is loaded below.
    m_valid_d     = m_valid_q && !m_axis_tready;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;
    trunc_d       = 1'b0;
    s_axis_tready = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d      = pick;
          last_grant_d = pick;
          beat_cnt_d   = '0;
          state_d      = ST_HDR;
        end
      end

      ST_HDR: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          m_data_d  = {HDR_TAG, 4'(grant_q), 4'h0, seq_q};
          seq_d     = seq_q + 16'd1;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        s_axis_tready[grant_q] = out_free;
        if (out_free && s_axis_tvalid[grant_q]) begin
          m_valid_d  = 1'b1;
          m_data_d   = src_data[grant_q];
          m_last_d   = s_axis_tlast[grant_q] || at_max;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (s_axis_tlast[grant_q]) begin
            state_d = ST_IDLE;
          end else if (at_max) begin
            trunc_d = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Overflow beats are swallowed until the source closes its frame.
        s_axis_tready[grant_q] = 1'b1;
        if (s_axis_tvalid[grant_q] && s_axis_tlast[grant_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(N_CHAN - 1);
      beat_cnt_q   <= '0;
      seq_q        <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      seq_q        <= seq_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      trunc_q      <= trunc_d;
    end
  end

  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tdata    = m_data_q;
  assign trunc_pulse_out = trunc_q;
  assign seq_out         = seq_q;
  assign busy_out        = (state_q != ST_IDLE) || m_valid_q;

endmodule
